// File: rtl/hilo_sched_pkg.sv
// Shared types for the HI/LO scheduler: decoded ops, op classes and the
// request payload passed between issue-slot selection and the FSM.
package hilo_sched_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [3:0] {
    OP_NOP   = 4'd0,
    OP_ADD   = 4'd1,
    OP_MULT  = 4'd2,
    OP_MULTU = 4'd3,
    OP_DIV   = 4'd4,
    OP_DIVU  = 4'd5,
    OP_MTHI  = 4'd6,
    OP_MTLO  = 4'd7,
    OP_MFHI  = 4'd8,
    OP_MFLO  = 4'd9
  } decoded_op_t;

  typedef enum logic [1:0] {
    NONE = 2'd0,
    LONG = 2'd1,
    WR   = 2'd2,
    RD   = 2'd3
  } hilo_class_t;

  typedef struct packed {
    decoded_op_t       op;
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } hilo_req_t;

  function automatic hilo_class_t op_class(input decoded_op_t op);
    hilo_class_t cls;
    case (op)
      OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: cls = LONG;
      OP_MTHI, OP_MTLO:                   cls = WR;
      OP_MFHI, OP_MFLO:                   cls = RD;
      default:                            cls = NONE;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/hilo_sched_sel.sv
// Picks at most one HI/LO-class op per cycle; the older slot 0 always wins.
module hilo_sel
  import hilo_sched_pkg::*;
(
  input  logic      i_valid0,
  input  hilo_req_t i_req0,
  input  logic      i_valid1,
  input  hilo_req_t i_req1,
  output logic      o_sel_valid,
  output hilo_req_t o_sel,
  output logic      o_sel_slot,
  output logic      o_conflict
);

  logic w_hit0;
  logic w_hit1;

  assign w_hit0 = i_valid0 && (op_class(i_req0.op) != NONE);
  assign w_hit1 = i_valid1 && (op_class(i_req1.op) != NONE);

  assign o_sel_valid = w_hit0 || w_hit1;
  assign o_sel_slot  = !w_hit0 && w_hit1;
  assign o_sel       = w_hit0 ? i_req0 : i_req1;
  assign o_conflict  = w_hit0 && w_hit1;

endmodule

// File: rtl/hilo_sched.sv
// Owns architectural HI/LO, sequences the shared mult/div unit and stalls
// the dual-issue pipeline while a long op is outstanding.
module hilo_sched
  import hilo_sched_pkg::*;
#(
  parameter int unsigned TIMEOUT = 64,
  parameter int unsigned CNT_W   = 7
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              req0_valid,
  input  decoded_op_t       req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  input  decoded_op_t       req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              stall0,
  output logic              stall1,
  output decoded_op_t       md_op,
  output logic [DATA_W-1:0] md_a,
  output logic [DATA_W-1:0] md_b,
  output logic              md_flush,
  input  logic              md_ok,
  input  logic [DATA_W-1:0] md_hi,
  input  logic [DATA_W-1:0] md_lo,
  output logic [DATA_W-1:0] hi_rd,
  output logic [DATA_W-1:0] lo_rd,
  output logic              busy,
  output logic              err
);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic              r_err, w_err_nxt;
  logic [DATA_W-1:0] r_hi, w_hi_nxt;
  logic [DATA_W-1:0] r_lo, w_lo_nxt;
  decoded_op_t       r_md_op, w_md_op_nxt;
  logic [DATA_W-1:0] r_md_a, w_md_a_nxt;
  logic [DATA_W-1:0] r_md_b, w_md_b_nxt;
  logic              w_stall0, w_stall1;
  logic [DATA_W-1:0] w_hi_rd, w_lo_rd;

  hilo_req_t   w_req0, w_req1, w_sel;
  logic        w_sel_valid, w_sel_slot, w_conflict;
  hilo_class_t w_sel_cls;

  assign w_req0 = '{op: req0_op, a: req0_a, b: req0_b};
  assign w_req1 = '{op: req1_op, a: req1_a, b: req1_b};

  hilo_sel u_sel (
    .i_valid0    (req0_valid),
    .i_req0      (w_req0),
    .i_valid1    (req1_valid),
    .i_req1      (w_req1),
    .o_sel_valid (w_sel_valid),
    .o_sel       (w_sel),
    .o_sel_slot  (w_sel_slot),
    .o_conflict  (w_conflict)
  );

  assign w_sel_cls = op_class(w_sel.op);

  // State, counter, HI/LO and unit-operand registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_err   <= 1'b0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_md_op <= OP_NOP;
      r_md_a  <= '0;
      r_md_b  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_err   <= w_err_nxt;
      r_hi    <= w_hi_nxt;
      r_lo    <= w_lo_nxt;
      r_md_op <= w_md_op_nxt;
      r_md_a  <= w_md_a_nxt;
      r_md_b  <= w_md_b_nxt;
    end
  end

  // Next state, commits, stalls and HI/LO forwarding
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_err_nxt   = r_err;
    w_hi_nxt    = r_hi;
    w_lo_nxt    = r_lo;
    w_md_op_nxt = r_md_op;
    w_md_a_nxt  = r_md_a;
    w_md_b_nxt  = r_md_b;
    w_stall0    = 1'b0;
    w_stall1    = 1'b0;
    w_hi_rd     = r_hi;
    w_lo_rd     = r_lo;

    unique case (r_state)
      ST_IDLE: begin
        if (!flush) begin
          w_stall1 = w_conflict;
          if (w_sel_valid) begin
            case (w_sel_cls)
              LONG: begin
                w_state_nxt = ST_BUSY;
                w_cnt_nxt   = '0;
                w_md_op_nxt = w_sel.op;
                w_md_a_nxt  = w_sel.a;
                w_md_b_nxt  = w_sel.b;
                if (w_sel_slot) w_stall1 = 1'b1;
                else            w_stall0 = 1'b1;
              end
              WR: begin
                if (w_sel.op == OP_MTHI) w_hi_nxt = w_sel.a;
                else                     w_lo_nxt = w_sel.a;
              end
              default: ;
            endcase
          end
        end
      end
      ST_BUSY: begin
        if (flush) begin
          // Abort wins even over a same-cycle result
          w_state_nxt = ST_IDLE;
          w_md_op_nxt = OP_NOP;
          w_cnt_nxt   = '0;
        end else if (md_ok) begin
          w_hi_rd     = md_hi;
          w_lo_rd     = md_lo;
          w_hi_nxt    = md_hi;
          w_lo_nxt    = md_lo;
          w_state_nxt = ST_IDLE;
          w_md_op_nxt = OP_NOP;
          w_cnt_nxt   = '0;
        end else begin
          w_stall0 = 1'b1;
          w_stall1 = 1'b1;
          if (r_cnt < CNT_W'(TIMEOUT)) w_cnt_nxt = r_cnt + CNT_W'(1);
          if (w_cnt_nxt == CNT_W'(TIMEOUT)) w_err_nxt = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign stall0   = reset & w_stall0;
  assign stall1   = reset & w_stall1;
  assign md_flush = reset & flush;
  assign hi_rd    = w_hi_rd;
  assign lo_rd    = w_lo_rd;
  assign md_op    = r_md_op;
  assign md_a     = r_md_a;
  assign md_b     = r_md_b;
  assign busy     = (r_state == ST_BUSY);
  assign err      = r_err;

endmodule

// File: tb/tb_hilo_sched.sv
// Bench for hilo_sched: directed scenarios then random traffic, checked
// against a transaction-level model of HI/LO and a mult/div unit emulator.
module tb_hilo_sched;
  import hilo_sched_pkg::*;

  localparam int TIMEOUT = 64;

  logic        clk = 1'b0;
  logic        reset, flush;
  logic        req0_valid, req1_valid;
  decoded_op_t req0_op, req1_op;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        stall0, stall1, md_flush, md_ok, busy, err;
  decoded_op_t md_op;
  logic [31:0] md_a, md_b, md_hi, md_lo, hi_rd, lo_rd;

  hilo_sched #(.TIMEOUT(64), .CNT_W(7)) dut (
    .clk(clk), .reset(reset), .flush(flush),
    .req0_valid(req0_valid), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .stall0(stall0), .stall1(stall1),
    .md_op(md_op), .md_a(md_a), .md_b(md_b), .md_flush(md_flush),
    .md_ok(md_ok), .md_hi(md_hi), .md_lo(md_lo),
    .hi_rd(hi_rd), .lo_rd(lo_rd), .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Architectural model plus unit emulator state
  bit          m_busy, m_err;
  int          m_cnt, u_wait, u_lat;
  logic [31:0] m_hi, m_lo, m_a, m_b;
  decoded_op_t m_op;
  int          next_lat = -1;
  bit          force_ok = 1'b0;
  bit          rand_ok  = 1'b0;

  logic        last_stall0, last_stall1, last_busy, last_err, last_md_flush;
  logic [31:0] last_hi_rd, last_lo_rd;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // 0 = ignored, 1 = long, 2 = HI/LO write, 3 = HI/LO read
  function automatic int hclass(input decoded_op_t op);
    if (op inside {OP_MULT, OP_MULTU, OP_DIV, OP_DIVU}) return 1;
    if (op inside {OP_MTHI, OP_MTLO}) return 2;
    if (op inside {OP_MFHI, OP_MFLO}) return 3;
    return 0;
  endfunction

  // {hi, lo} the real unit would return
  function automatic logic [63:0] md_result(input decoded_op_t op, input logic [31:0] a,
                                            input logic [31:0] b);
    longint sa, sb;
    logic [63:0] r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    r  = '0;
    case (op)
      OP_MULT:  r = 64'(sa * sb);
      OP_MULTU: r = {32'd0, a} * {32'd0, b};
      OP_DIV:   if (b != 0) r = {32'(sa % sb), 32'(sa / sb)};
      OP_DIVU:  if (b != 0) r = {a % b, a / b};
      default:  ;
    endcase
    return r;
  endfunction

  task automatic model_reset();
    m_busy = 0; m_err = 0; m_cnt = 0; u_wait = 0; u_lat = 0;
    m_hi = '0; m_lo = '0; m_a = '0; m_b = '0; m_op = OP_NOP;
  endtask

  task automatic set_req(input bit v0, input decoded_op_t o0, input logic [31:0] a0,
                         input logic [31:0] b0, input bit v1, input decoded_op_t o1,
                         input logic [31:0] a1, input logic [31:0] b1);
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
  endtask

  task automatic idle_req();
    set_req(0, OP_NOP, '0, '0, 0, OP_NOP, '0, '0);
  endtask

  // One clock: drive the unit, check before the edge, then advance the model
  task automatic cycle();
    bit          hl0, hl1, e_s0, e_s1, take1;
    logic [31:0] e_hi, e_lo;
    logic [63:0] res;
    int          cls;
    md_ok = 1'b0;
    md_hi = $urandom;
    md_lo = $urandom;
    if (m_busy && u_wait == u_lat) begin
      res   = md_result(m_op, m_a, m_b);
      md_ok = 1'b1;
      md_hi = res[63:32];
      md_lo = res[31:0];
    end else if (!m_busy && (force_ok || (rand_ok && $urandom_range(0, 19) == 0))) begin
      md_ok = 1'b1;
    end
    #3;
    hl0  = req0_valid && hclass(req0_op) != 0;
    hl1  = req1_valid && hclass(req1_op) != 0;
    e_s0 = 0; e_s1 = 0; e_hi = m_hi; e_lo = m_lo;
    if (reset && !flush) begin
      if (!m_busy) begin
        if (hl0) begin
          e_s0 = (hclass(req0_op) == 1);
          e_s1 = hl1;
        end else if (hl1) begin
          e_s1 = (hclass(req1_op) == 1);
        end
      end else if (md_ok) begin
        e_hi = md_hi; e_lo = md_lo;
      end else begin
        e_s0 = 1; e_s1 = 1;
      end
    end
    last_stall0 = stall0; last_stall1 = stall1; last_busy = busy; last_err = err;
    last_md_flush = md_flush; last_hi_rd = hi_rd; last_lo_rd = lo_rd;
    chk("stall0", 64'(stall0), 64'(e_s0));
    chk("stall1", 64'(stall1), 64'(e_s1));
    chk("md_flush", 64'(md_flush), 64'(reset && flush));
    if (reset) begin
      chk("hi_rd", 64'(hi_rd), 64'(e_hi));
      chk("lo_rd", 64'(lo_rd), 64'(e_lo));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("err", 64'(err), 64'(m_err));
      chk("md_op", 64'(md_op), 64'(m_op));
      chk("md_a", 64'(md_a), 64'(m_a));
      chk("md_b", 64'(md_b), 64'(m_b));
    end
    if (!reset) begin
      model_reset();
    end else if (m_busy) begin
      if (flush) begin
        m_busy = 0; m_op = OP_NOP; m_cnt = 0;
      end else if (md_ok) begin
        m_hi = md_hi; m_lo = md_lo; m_busy = 0; m_op = OP_NOP; m_cnt = 0;
      end else begin
        if (m_cnt < TIMEOUT) m_cnt++;
        if (m_cnt == TIMEOUT) m_err = 1;
        u_wait++;
      end
    end else if (!flush && (hl0 || hl1)) begin
      take1 = !hl0;
      cls   = take1 ? hclass(req1_op) : hclass(req0_op);
      if (cls == 1) begin
        m_busy = 1; m_cnt = 0; u_wait = 0;
        m_op = take1 ? req1_op : req0_op;
        m_a  = take1 ? req1_a : req0_a;
        m_b  = take1 ? req1_b : req0_b;
        if (next_lat >= 0) u_lat = next_lat;
        else u_lat = ($urandom_range(0, 9) == 0) ? 1000 : int'($urandom_range(0, 40));
        next_lat = -1;
      end else if (cls == 2) begin
        if ((take1 ? req1_op : req0_op) == OP_MTHI) m_hi = take1 ? req1_a : req0_a;
        else                                        m_lo = take1 ? req1_a : req0_a;
      end
    end
    @(posedge clk);
    #1;
  endtask

  function automatic decoded_op_t rand_op();
    return decoded_op_t'(4'($urandom_range(0, 9)));
  endfunction

  initial begin
    int stall_cnt;
    model_reset();
    reset = 1'b0; flush = 1'b0; md_ok = 1'b0; md_hi = '0; md_lo = '0;
    idle_req();
    cycle();
    cycle();
    reset = 1'b1;
    cycle();
    chk("rst_hi", 64'(last_hi_rd), 64'd0);
    chk("rst_busy", 64'(last_busy), 64'd0);

    // MULTU 3*5 with 16 stalled busy cycles before the result
    set_req(1, OP_MULTU, 32'd3, 32'd5, 0, OP_NOP, '0, '0);
    next_lat = 16;
    cycle();
    chk("multu_accept_stall", 64'(last_stall0), 64'd1);
    idle_req();
    stall_cnt = 0;
    repeat (16) begin
      cycle();
      if (last_stall0) stall_cnt++;
    end
    chk("multu_stall_cycles", 64'(stall_cnt), 64'd16);
    cycle();
    chk("multu_fwd_lo", 64'(last_lo_rd), 64'd15);
    chk("multu_ok_nostall", 64'(last_stall0), 64'd0);
    cycle();
    chk("multu_lo_q", 64'(last_lo_rd), 64'd15);

    // MTHI in slot 0 blocks MFHI in slot 1 for one cycle
    set_req(1, OP_MTHI, 32'hDEAD0000, '0, 1, OP_MFHI, '0, '0);
    cycle();
    chk("mthi_stall1", 64'(last_stall1), 64'd1);
    idle_req();
    cycle();
    chk("mthi_hi", 64'(last_hi_rd), 64'hDEAD0000);

    // DIV flushed in its fifth cycle; a stray md_ok afterwards is ignored
    set_req(1, OP_DIV, 32'hFFFF_FFF9, 32'd2, 0, OP_NOP, '0, '0);
    next_lat = 30;
    cycle();
    idle_req();
    repeat (3) cycle();
    flush = 1'b1;
    cycle();
    chk("div_md_flush", 64'(last_md_flush), 64'd1);
    chk("div_flush_stall", 64'(last_stall0), 64'd0);
    flush = 1'b0;
    force_ok = 1'b1;
    cycle();
    chk("div_flushed_idle", 64'(last_busy), 64'd0);
    force_ok = 1'b0;
    cycle();
    chk("div_keep_hi", 64'(last_hi_rd), 64'hDEAD0000);
    chk("div_keep_lo", 64'(last_lo_rd), 64'd15);

    // DIVU never completes: err rises when the counter reaches TIMEOUT
    set_req(1, OP_DIVU, 32'd100, 32'd7, 0, OP_NOP, '0, '0);
    next_lat = 1000;
    cycle();
    idle_req();
    repeat (TIMEOUT) cycle();
    chk("to_err_before", 64'(last_err), 64'd0);
    cycle();
    chk("to_err_set", 64'(last_err), 64'd1);
    chk("to_stall", 64'(last_stall0), 64'd1);
    flush = 1'b1;
    cycle();
    chk("to_flush_release", 64'(last_stall0), 64'd0);
    flush = 1'b0;
    cycle();
    chk("to_err_sticky", 64'(last_err), 64'd1);

    // Result cycle forwards to MFLO and refuses a new long op
    set_req(1, OP_MULTU, 32'd7, 32'd9, 0, OP_NOP, '0, '0);
    next_lat = 5;
    cycle();
    idle_req();
    repeat (5) cycle();
    set_req(1, OP_MULT, 32'd1, 32'd1, 1, OP_MFLO, '0, '0);
    cycle();
    chk("ok_fwd_lo", 64'(last_lo_rd), 64'd63);
    idle_req();
    cycle();
    chk("ok_no_accept", 64'(last_busy), 64'd0);

    // Random traffic
    rand_ok = 1'b1;
    for (int c = 0; c < 4000; c++) begin
      reset = ($urandom_range(0, 499) != 0);
      flush = ($urandom_range(0, 39) == 0);
      set_req(1'($urandom), rand_op(), $urandom, $urandom,
              1'($urandom), rand_op(), $urandom, $urandom);
      cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
